// File: rtl/otp_prog_ctrl.sv
// OTP byte programmer: burns masked bits one per cycle, then optionally reads back and compares.
// Build option: define OTP_PROG_VERIFY_EN to enable the read-back/verify phase (RD, RD_WAIT).
module otp_prog_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_data,
  input  logic [7:0]        req_mask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_ok,
  output logic [7:0]        resp_rdata,
  output logic              otp_prog_en,
  output logic [ADDR_W-1:0] otp_prog_addr,
  output logic [2:0]        otp_prog_bit,
  output logic              otp_prog_data,
  output logic              otp_read_en,
  output logic [ADDR_W-1:0] otp_read_addr,
  input  logic [7:0]        otp_read_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROG    = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [7:0]        mask_q;
  logic [2:0]        bit_q;
  logic [2:0]        bit_d;
  logic              prog_en_q;
  logic              prog_data_q;
  logic              resp_valid_q;
  logic              resp_ok_q;
  logic [7:0]        resp_rdata_q;

  assign bit_d = bit_q + 3'd1;

`ifdef OTP_PROG_VERIFY_EN
  logic              read_en_q;
  logic [ADDR_W-1:0] read_addr_q;

  assign otp_read_en   = read_en_q;
  assign otp_read_addr = read_addr_q;
`else
  logic unused_read_data;

  assign unused_read_data = ^otp_read_data;
  assign otp_read_en      = 1'b0;
  assign otp_read_addr    = '0;
`endif

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_ok       = resp_ok_q;
  assign resp_rdata    = resp_rdata_q;
  assign otp_prog_en   = prog_en_q;
  assign otp_prog_addr = addr_q;
  assign otp_prog_bit  = bit_q;
  assign otp_prog_data = prog_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= 8'h00;
      mask_q       <= 8'h00;
      bit_q        <= 3'd0;
      prog_en_q    <= 1'b0;
      prog_data_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_rdata_q <= 8'h00;
`ifdef OTP_PROG_VERIFY_EN
      read_en_q    <= 1'b0;
      read_addr_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Strobes are registered, so bit 0 is driven in the first PROG cycle.
            state_q     <= PROG;
            addr_q      <= req_addr;
            data_q      <= req_data;
            mask_q      <= req_mask;
            bit_q       <= 3'd0;
            prog_en_q   <= req_mask[0];
            prog_data_q <= req_data[0];
          end
        end
        PROG: begin
          if (bit_q == 3'd7) begin
            bit_q       <= 3'd0;
            prog_en_q   <= 1'b0;
            prog_data_q <= 1'b0;
`ifdef OTP_PROG_VERIFY_EN
            state_q     <= RD;
            read_en_q   <= 1'b1;
            read_addr_q <= addr_q;
`else
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_ok_q    <= 1'b1;
            resp_rdata_q <= 8'h00;
`endif
          end else begin
            bit_q       <= bit_d;
            prog_en_q   <= mask_q[bit_d];
            prog_data_q <= data_q[bit_d];
          end
        end
`ifdef OTP_PROG_VERIFY_EN
        RD: begin
          read_en_q <= 1'b0;
          state_q   <= RD_WAIT;
        end
        RD_WAIT: begin
          // Only masked bits matter; unmasked bits may hold anything.
          resp_rdata_q <= otp_read_data;
          resp_ok_q    <= (((otp_read_data ^ data_q) & mask_q) == 8'h00);
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
`endif
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_prog_ctrl.sv
// Scoreboard bench for otp_prog_ctrl with a one-time-programmable array model.
module tb_otp_prog_ctrl;

  localparam int ADDR_W = 3;
`ifdef OTP_PROG_VERIFY_EN
  localparam int RESP_LAT = 11;
`else
  localparam int RESP_LAT = 9;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_data;
  logic [7:0]        req_mask;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_ok;
  logic [7:0]        resp_rdata;
  logic              otp_prog_en;
  logic [ADDR_W-1:0] otp_prog_addr;
  logic [2:0]        otp_prog_bit;
  logic              otp_prog_data;
  logic              otp_read_en;
  logic [ADDR_W-1:0] otp_read_addr;
  logic [7:0]        otp_read_data = 8'h00;

  otp_prog_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_ok(resp_ok), .resp_rdata(resp_rdata),
    .otp_prog_en(otp_prog_en), .otp_prog_addr(otp_prog_addr),
    .otp_prog_bit(otp_prog_bit), .otp_prog_data(otp_prog_data),
    .otp_read_en(otp_read_en), .otp_read_addr(otp_read_addr),
    .otp_read_data(otp_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // OTP array: the first program of a bit fixes its value forever; fresh bits read 0.
  logic [7:0] otp_val  [8] = '{default: 8'h00};
  logic [7:0] otp_burn [8] = '{default: 8'h00};
  always @(posedge clk) begin
    if (otp_prog_en && !otp_burn[otp_prog_addr][otp_prog_bit]) begin
      otp_val[otp_prog_addr][otp_prog_bit]  <= otp_prog_data;
      otp_burn[otp_prog_addr][otp_prog_bit] <= 1'b1;
    end
    if (otp_read_en) otp_read_data <= otp_val[otp_read_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        mask;
    logic [7:0]        rdata;
    logic              ok;
  } exp_t;

  exp_t q[$];

  // Driver-owned signalling to the monitor
  int idle_req    = 0;
  int timeout_cnt = 0;
  bit b2b_flag    = 1'b0;
  bit fin         = 1'b0;

  // Monitor-owned state
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int idle_seen = 0;
  int overlap_cnt = 0;
  int acc_cyc = -100;
  int val_cyc = -1;
  int rd_cyc = -1;
  int hs_cyc = -100;
  logic [7:0] obs_en = 8'h00;
  logic [7:0] obs_dat = 8'h00;
  bit seq_err = 1'b0;
  logic snap_ok;
  logic [7:0] snap_rd;
  bit fin_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (idle_req != idle_seen) begin
      idle_seen = idle_req;
      check("idle_req_ready", int'(req_ready), 1);
      check("idle_prog_en", int'(otp_prog_en), 0);
      check("idle_read_en", int'(otp_read_en), 0);
      check("idle_resp_valid", int'(resp_valid), 0);
      check("idle_resp_ok", int'(resp_ok), 0);
      check("idle_resp_rdata", int'(resp_rdata), 0);
      check("idle_prog_bit", int'(otp_prog_bit), 0);
      check("idle_prog_addr", int'(otp_prog_addr), 0);
      check("idle_read_addr", int'(otp_read_addr), 0);
      check("idle_prog_data", int'(otp_prog_data), 0);
    end
    if (!rst_n) begin
      acc_cyc = -100; val_cyc = -1; rd_cyc = -1;
      obs_en = 8'h00; obs_dat = 8'h00; seq_err = 1'b0;
    end else begin
      if (otp_prog_en && otp_read_en) overlap_cnt++;
      if (req_valid && req_ready) begin
        if (b2b_flag) check("accept_after_handshake", cyc, hs_cyc + 1);
        acc_cyc = cyc; val_cyc = -1; rd_cyc = -1;
        obs_en = 8'h00; obs_dat = 8'h00; seq_err = 1'b0;
      end
      if (otp_prog_en) begin
        obs_en[otp_prog_bit]  = 1'b1;
        obs_dat[otp_prog_bit] = otp_prog_data;
        if (cyc - acc_cyc - 1 != int'(otp_prog_bit)) seq_err = 1'b1;
        if (q.size() > 0 && otp_prog_addr != q[0].addr) seq_err = 1'b1;
      end
      if (otp_read_en) begin
        rd_cyc = cyc;
        if (q.size() > 0 && otp_read_addr != q[0].addr) seq_err = 1'b1;
      end
      if (resp_valid) begin
        check("req_ready_low_in_resp", int'(req_ready), 0);
        if (q.size() == 0) begin
          check("spurious_resp_valid", int'(resp_valid), 0);
        end else begin
          if (val_cyc < 0) begin
            val_cyc = cyc; snap_ok = resp_ok; snap_rd = resp_rdata;
          end else begin
            check("stall_resp_ok", int'(resp_ok), int'(snap_ok));
            check("stall_resp_rdata", int'(resp_rdata), int'(snap_rd));
          end
          if (resp_ready) begin
            exp_t e;
            e = q.pop_front();
            $display("[TB] txn addr=%0d data=%02h mask=%02h -> ok=%0b rdata=%02h lat=%0d",
                     e.addr, e.data, e.mask, resp_ok, resp_rdata, val_cyc - acc_cyc);
            check("resp_ok", int'(resp_ok), int'(e.ok));
            check("resp_rdata", int'(resp_rdata), int'(e.rdata));
            check("prog_en_bits", int'(obs_en), int'(e.mask));
            check("prog_data_bits", int'(obs_dat & e.mask), int'(e.data & e.mask));
            check("prog_sequence", int'(seq_err), 0);
            check("resp_latency", val_cyc - acc_cyc, RESP_LAT);
`ifdef OTP_PROG_VERIFY_EN
            check("read_latency", rd_cyc - acc_cyc, 9);
`else
            check("read_en_never", rd_cyc, -1);
`endif
            hs_cyc = cyc;
            done_cnt++;
          end
        end
      end
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      check("prog_read_overlap", overlap_cnt, 0);
      check("timeouts", timeout_cnt, 0);
      check("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      timeout_cnt++;
      $display("[TB] FAIL accept_timeout: req_ready still 0, expected 1");
    end
    @(posedge clk); #1;
    // Scramble request inputs to show they are not re-sampled.
    req_valid = 1'b0;
    req_addr  = ~req_addr;
    req_data  = ~req_data;
    req_mask  = ~req_mask;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic [7:0] m,
                       input logic eok, input logic [7:0] erd, input bit push);
    exp_t e;
    e.addr = a; e.data = d; e.mask = m;
`ifdef OTP_PROG_VERIFY_EN
    e.ok = eok; e.rdata = erd;
`else
    e.ok = 1'b1; e.rdata = 8'h00;
`endif
    if (push) q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_data = d; req_mask = m;
    wait_accept();
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 80) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 80) begin
      timeout_cnt++;
      $display("[TB] FAIL resp_timeout: done=%0d, expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    int n;
    exp_t e2;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = 8'h00; req_mask = 8'h00;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; idle_req++;

    issue(3'd3, 8'hA5, 8'hFF, 1'b1, 8'hA5, 1'b1); wait_done(1);
    issue(3'd3, 8'h5A, 8'hFF, 1'b0, 8'hA5, 1'b1); wait_done(2);
    issue(3'd7, 8'hFF, 8'h0F, 1'b1, 8'h0F, 1'b1); wait_done(3);
    issue(3'd5, 8'h3C, 8'h00, 1'b1, 8'h00, 1'b1); wait_done(4);

    // Response back-pressure with a second request waiting
    resp_ready = 1'b0;
    issue(3'd1, 8'h81, 8'h81, 1'b1, 8'h81, 1'b1);
    @(posedge clk); #1;
    e2.addr = 3'd2; e2.data = 8'h0F; e2.mask = 8'hF0;
`ifdef OTP_PROG_VERIFY_EN
    e2.ok = 1'b1; e2.rdata = 8'h00;
`else
    e2.ok = 1'b1; e2.rdata = 8'h00;
`endif
    q.push_back(e2);
    req_valid = 1'b1; req_addr = 3'd2; req_data = 8'h0F; req_mask = 8'hF0; b2b_flag = 1'b1;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) begin
      timeout_cnt++;
      $display("[TB] FAIL stall_resp_timeout: resp_valid 0, expected 1");
    end
    repeat (5) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    wait_accept();
    b2b_flag = 1'b0;
    wait_done(6);

    // Reset during the 4th PROG cycle: bits 0..3 end up burned
    issue(3'd6, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; idle_req++;
    repeat (15) @(posedge clk);
    #1;
    issue(3'd6, 8'h00, 8'hFF, 1'b0, 8'h0F, 1'b1); wait_done(7);
    issue(3'd7, 8'hF0, 8'hF0, 1'b1, 8'hFF, 1'b1); wait_done(8);

    repeat (3) @(posedge clk);
    #1 fin = 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/otp_prog_ctrl.md
OTP_PROG_CTRL -- requirements
Module: otp_prog_ctrl

Interface
REQ-001 Parameter ADDR_W, default 3, sets the OTP word address width; the array holds 2**ADDR_W bytes.
REQ-002 The block SHALL have one clock, clk, and a synchronous active-low reset, rst_n.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  program request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  target byte address
- req_data  in  8  value to burn
- req_mask  in  8  per-bit enable; 1 = burn this bit
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_ok  out  1  readback matched on all masked bits
- resp_rdata  out  8  byte read back from the OTP
- otp_prog_en  out  1  OTP program strobe
- otp_prog_addr  out  ADDR_W  OTP program address
- otp_prog_bit  out  3  OTP program bit index
- otp_prog_data  out  1  OTP program bit value
- otp_read_en  out  1  OTP read strobe
- otp_read_addr  out  ADDR_W  OTP read address
- otp_read_data  in  8  OTP read data; valid the cycle after otp_read_en

Function
REQ-004 States SHALL be IDLE, PROG, RD, RD_WAIT and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-006 On accept, the block SHALL latch addr, data and mask, and go to PROG with bit counter 0.
REQ-007 PROG SHALL last exactly 8 cycles, bit i in the (i+1)th cycle:
- otp_prog_bit = i, otp_prog_addr = latched addr, otp_prog_data = data[i]
- otp_prog_en = mask[i]
REQ-008 A mask of 8'h00 SHALL still take 8 PROG cycles, with otp_prog_en held at 0 throughout.
REQ-009 RD SHALL last one cycle with otp_read_en = 1 and otp_read_addr = latched addr.
REQ-010 RD_WAIT SHALL last one cycle, then capture otp_read_data into resp_rdata.
REQ-011 In the same RD_WAIT cycle, resp_ok SHALL be set to ((otp_read_data ^ data) & mask) == 0.
REQ-012 In RESP, resp_valid SHALL be 1, and resp_ok and resp_rdata SHALL be stable until resp_valid && resp_ready.
REQ-013 On the resp_valid && resp_ready cycle the block SHALL return to IDLE; req_ready = 1 on the next cycle.
REQ-014 Latency SHALL be fixed:
- accept at cycle T
- PROG T+1..T+8
- RD T+9
- RD_WAIT T+10
- resp_valid first high at T+11
REQ-015 A bit already burned to the opposite value is reported via resp_ok = 0; the block SHALL NOT retry.
REQ-016 otp_prog_en and otp_read_en SHALL never be high in the same cycle.
REQ-017 Address 2**ADDR_W-1 SHALL be handled with no wrap or special case.
REQ-018 req_* changes after accept SHALL have no effect on the operation in progress.

Reset
REQ-019 When rst_n = 0 at a clk edge, the block SHALL:
- enter IDLE
- clear otp_prog_en, otp_read_en, resp_valid, resp_ok, resp_rdata, otp_prog_bit, otp_prog_addr, otp_read_addr and otp_prog_data to 0
- set req_ready = 1 on the first cycle after rst_n returns to 1
REQ-020 Reset mid-PROG SHALL stop strobes on the next cycle and produce no response; bits already burned remain burned.

Configuration
REQ-021 Macro OTP_PROG_VERIFY_EN defined: behaviour SHALL be as in REQ-009..REQ-014.
REQ-022 Macro OTP_PROG_VERIFY_EN undefined:
- RD and RD_WAIT are omitted and otp_read_en is tied to 0
- RESP follows PROG, with resp_valid first high at T+9
- resp_ok = 1 and resp_rdata = 8'h00

Verification
REQ-023 Fresh OTP, addr 3, data 8'hA5, mask 8'hFF -> 8 prog_en pulses with bits 0..7 and data 1,0,1,0,0,1,0,1; read_en at T+9; resp_valid at T+11, resp_ok = 1, resp_rdata = 8'hA5.
REQ-024 After REQ-023, addr 3, data 8'h5A, mask 8'hFF -> resp_ok = 0, resp_rdata = 8'hA5.
REQ-025 addr 7, data 8'hFF, mask 8'h0F -> prog_en only on bits 0..3; resp_ok = 1; resp_rdata[3:0] = 4'hF.
REQ-026 resp_ready held 0 for 5 cycles after resp_valid -> resp_valid, resp_ok and resp_rdata stable; req_ready = 0; a second req_valid is not accepted until after the handshake.
REQ-027 rst_n = 0 during the 4th PROG cycle -> next cycle prog_en = 0 and state IDLE; no resp_valid; a new request is accepted normally.
REQ-028 Build without OTP_PROG_VERIFY_EN -> read_en never asserted; resp_valid at T+9 with resp_ok = 1.
